dbg_bus_arbiter: RTL and testbench

//  Shares the microcontroller's single peripheral/memory bus between two requesters: the CPU

---
 rtl/dbg_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dbg_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_arbiter.sv
// Two-requester bus arbiter (CPU core C, UART debug port D) onto a single target bus.
// One transaction in flight, round-robin on contention, debug hold-off and a no-ack watchdog.
module dbg_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_be,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  input  logic              dbg_hold,
  output logic              t_req,
  output logic              t_we,
  output logic [ADDR_W-1:0] t_addr,
  output logic [31:0]       t_wdata,
  output logic [3:0]        t_be,
  input  logic              t_ack,
  input  logic [31:0]       t_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_D} state_t;

  state_t              state, state_nxt;
  logic                last_d, last_d_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                t_req_nxt, t_we_nxt;
  logic [ADDR_W-1:0]   t_addr_nxt;
  logic [31:0]         t_wdata_nxt;
  logic [3:0]          t_be_nxt;
  logic                c_gnt_nxt, c_rvalid_nxt, c_err_nxt;
  logic                d_gnt_nxt, d_rvalid_nxt, d_err_nxt;
  logic [31:0]         c_rdata_nxt, d_rdata_nxt;
  logic                elig_c, elig_d, pick_c, pick_d, timeout_hit;
  logic [31:0]         done_rdata;
  logic                done_err;

  // CPU wins contention unless it owned the bus last
  assign elig_c = c_req & ~dbg_hold;
  assign elig_d = d_req;
  assign pick_c = elig_c & (~elig_d | last_d);
  assign pick_d = elig_d & (~elig_c | ~last_d);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      cnt      <= '0;
      t_req    <= 1'b0;
      t_we     <= 1'b0;
      t_addr   <= '0;
      t_wdata  <= '0;
      t_be     <= '0;
      c_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      c_err    <= 1'b0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      cnt      <= cnt_nxt;
      t_req    <= t_req_nxt;
      t_we     <= t_we_nxt;
      t_addr   <= t_addr_nxt;
      t_wdata  <= t_wdata_nxt;
      t_be     <= t_be_nxt;
      c_gnt    <= c_gnt_nxt;
      c_rvalid <= c_rvalid_nxt;
      c_rdata  <= c_rdata_nxt;
      c_err    <= c_err_nxt;
      d_gnt    <= d_gnt_nxt;
      d_rvalid <= d_rvalid_nxt;
      d_rdata  <= d_rdata_nxt;
      d_err    <= d_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_d_nxt   = last_d;
    cnt_nxt      = cnt;
    t_req_nxt    = t_req;
    t_we_nxt     = t_we;
    t_addr_nxt   = t_addr;
    t_wdata_nxt  = t_wdata;
    t_be_nxt     = t_be;
    c_gnt_nxt    = 1'b0;
    c_rvalid_nxt = 1'b0;
    c_rdata_nxt  = c_rdata;
    c_err_nxt    = c_err;
    d_gnt_nxt    = 1'b0;
    d_rvalid_nxt = 1'b0;
    d_rdata_nxt  = d_rdata;
    d_err_nxt    = d_err;
    done_rdata   = '0;
    done_err     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_c) begin
          t_we_nxt    = c_we;
          t_addr_nxt  = c_addr;
          t_wdata_nxt = c_wdata;
          t_be_nxt    = c_be;
          t_req_nxt   = 1'b1;
          c_gnt_nxt   = 1'b1;
          last_d_nxt  = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = BUSY_C;
        end else if (pick_d) begin
          t_we_nxt    = d_we;
          t_addr_nxt  = d_addr;
          t_wdata_nxt = d_wdata;
          t_be_nxt    = d_be;
          t_req_nxt   = 1'b1;
          d_gnt_nxt   = 1'b1;
          last_d_nxt  = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = BUSY_D;
        end
      end
      BUSY_C, BUSY_D: begin
        // ack takes priority over a watchdog expiry in the same cycle
        if (t_ack || timeout_hit) begin
          done_rdata = (t_ack && !t_we) ? t_rdata : 32'd0;
          done_err   = ~t_ack;
          t_req_nxt  = 1'b0;
          state_nxt  = IDLE;
          if (state == BUSY_D) begin
            d_rvalid_nxt = 1'b1;
            d_rdata_nxt  = done_rdata;
            d_err_nxt    = done_err;
          end else begin
            c_rvalid_nxt = 1'b1;
            c_rdata_nxt  = done_rdata;
            c_err_nxt    = done_err;
          end
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed bench for dbg_bus_arbiter: arbitration order, hold-off, watchdog, async reset, writes.
module tb_dbg_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, dbg_hold, t_ack;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, t_rdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        t_req, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbg_bus_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .dbg_hold(dbg_hold),
    .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata), .t_be(t_be),
    .t_ack(t_ack), .t_rdata(t_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    dbg_hold = 0; t_ack = 0; t_rdata = 0;
    tick(); tick();
    chk("rst_t_req", 32'(t_req), 0);
    chk("rst_c_gnt", 32'(c_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_c_rvalid", 32'(c_rvalid), 0);
    chk("rst_t_addr", t_addr, 0);
    reset = 1'b1;
    tick();

    // contention: alternate C,D,C,D with immediate ack
    c_req = 1; c_addr = 32'h200; c_be = 4'hF;
    d_req = 1; d_addr = 32'h300; d_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_c_gnt", 32'(c_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_d_gnt", 32'(d_gnt), (i % 2 == 1) ? 1 : 0);
      chk("rr_t_addr", t_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      t_ack = 1; t_rdata = 32'h1000 + 32'(i);
      tick();
      t_ack = 0;
      chk("rr_c_rvalid", 32'(c_rvalid), (i % 2 == 0) ? 1 : 0);
      chk("rr_d_rvalid", 32'(d_rvalid), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) chk("rr_c_rdata", c_rdata, 32'h1000 + 32'(i));
      else            chk("rr_d_rdata", d_rdata, 32'h1000 + 32'(i));
    end
    c_req = 0; d_req = 0;
    tick();

    // single CPU read
    c_req = 1; c_we = 0; c_addr = 32'h100;
    tick();
    chk("rd_c_gnt", 32'(c_gnt), 1);
    chk("rd_t_req", 32'(t_req), 1);
    chk("rd_t_we", 32'(t_we), 0);
    chk("rd_t_addr", t_addr, 32'h100);
    c_req = 0; t_ack = 1; t_rdata = 32'h12345678;
    tick();
    t_ack = 0;
    chk("rd_c_rvalid", 32'(c_rvalid), 1);
    chk("rd_c_rdata", c_rdata, 32'h12345678);
    chk("rd_c_err", 32'(c_err), 0);
    chk("rd_t_req_low", 32'(t_req), 0);
    chk("rd_d_rvalid", 32'(d_rvalid), 0);
    chk("rd_d_gnt", 32'(d_gnt), 0);
    tick();
    chk("rd_c_rvalid_pulse", 32'(c_rvalid), 0);
    chk("rd_c_rdata_hold", c_rdata, 32'h12345678);

    // CPU write, data held through BUSY_C, rdata zero on completion
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hAABBCCDD; c_be = 4'b0011;
    tick();
    chk("wr_c_gnt", 32'(c_gnt), 1);
    chk("wr_t_we", 32'(t_we), 1);
    chk("wr_t_be", 32'(t_be), 32'h3);
    chk("wr_t_wdata", t_wdata, 32'hAABBCCDD);
    c_req = 0; c_we = 0; c_wdata = 0; c_be = 4'hF;
    tick();
    chk("wr_t_wdata_stable", t_wdata, 32'hAABBCCDD);
    chk("wr_t_req_held", 32'(t_req), 1);
    t_ack = 1; t_rdata = 32'hDEADBEEF;
    tick();
    t_ack = 0;
    chk("wr_c_rvalid", 32'(c_rvalid), 1);
    chk("wr_c_rdata", c_rdata, 0);
    tick();

    // dbg_hold: only D granted, then CPU wins once released
    dbg_hold = 1; c_req = 1; d_req = 1; c_addr = 32'h500; d_addr = 32'h600;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_d_gnt", 32'(d_gnt), 1);
      chk("hold_c_gnt", 32'(c_gnt), 0);
      t_ack = 1; t_rdata = 32'h77;
      tick();
      t_ack = 0;
      chk("hold_d_rvalid", 32'(d_rvalid), 1);
    end
    dbg_hold = 0;
    tick();
    chk("unhold_c_gnt", 32'(c_gnt), 1);
    chk("unhold_d_gnt", 32'(d_gnt), 0);
    t_ack = 1; t_rdata = 32'hCAFE0001;
    tick();
    t_ack = 0; c_req = 0; d_req = 0;
    chk("unhold_c_rvalid", 32'(c_rvalid), 1);
    chk("unhold_c_rdata", c_rdata, 32'hCAFE0001);
    tick();

    // watchdog: no ack, t_req high exactly 4 cycles
    c_req = 1; c_addr = 32'h700;
    tick();
    c_req = 0;
    for (int k = 0; k < 4; k++) begin
      chk("to_t_req_high", 32'(t_req), 1);
      tick();
    end
    chk("to_t_req_low", 32'(t_req), 0);
    chk("to_c_rvalid", 32'(c_rvalid), 1);
    chk("to_c_err", 32'(c_err), 1);
    chk("to_c_rdata", c_rdata, 0);
    tick();

    // ack on the 4th cycle beats the watchdog
    c_req = 1;
    tick();
    c_req = 0;
    tick(); tick(); tick();
    chk("ack4_t_req", 32'(t_req), 1);
    t_ack = 1; t_rdata = 32'h55;
    tick();
    t_ack = 0;
    chk("ack4_c_rvalid", 32'(c_rvalid), 1);
    chk("ack4_c_err", 32'(c_err), 0);
    chk("ack4_c_rdata", c_rdata, 32'h55);
    tick();

    // async reset during BUSY_D
    d_req = 1; d_addr = 32'h800;
    tick();
    chk("rst_busy_d_gnt", 32'(d_gnt), 1);
    d_req = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_t_req", 32'(t_req), 0);
    tick();
    reset = 1'b1;
    t_ack = 1; t_rdata = 32'h99;
    tick();
    t_ack = 0;
    chk("rst_no_d_rvalid", 32'(d_rvalid), 0);
    tick();
    chk("rst_no_d_rvalid2", 32'(d_rvalid), 0);
    c_req = 1; d_req = 1; c_addr = 32'h900; d_addr = 32'hA00;
    tick();
    chk("rst_first_c_gnt", 32'(c_gnt), 1);
    chk("rst_first_d_gnt", 32'(d_gnt), 0);
    c_req = 0; d_req = 0; t_ack = 1; t_rdata = 32'h1;
    tick();
    t_ack = 0;
    chk("rst_first_c_rvalid", 32'(c_rvalid), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
